// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display path: digit count,
// active-low seven-segment codes and the packed M.SS time record.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_W     = $clog2(NUM_DIGITS);
    localparam int DP_DIGIT   = 1;

    // Segment order is {g,f,e,d,c,b,a}; a cleared bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef logic [SCAN_W-1:0] scan_idx_t;

    typedef struct packed {
        logic [3:0] minutes;
        logic [2:0] sec_tens;
        logic [3:0] sec_ones;
    } sw_time_t;

    // One-cold anode pattern for the digit selected by the scan index.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input scan_idx_t idx);
        logic [NUM_DIGITS-1:0] an;
        an      = '1;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 blank
// the digit so an out-of-range input never shows a bogus glyph.
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: the default arm assigns seg on every path, so no latch is inferred.
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// Extends the upstream tenths digit into seconds and minutes, and scans the
// four digits M.SS.t onto a common-anode display with registered pin drivers.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            tenths,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [3:0]            sec_ones,
    output logic [2:0]            sec_tens,
    output logic [3:0]            minutes,
    output logic                  rollover
);

    localparam int              CNT_W        = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [3:0]            prev_tenths_q, prev_tenths_d;
    sw_time_t              time_q, time_d;
    logic                  rollover_q, rollover_d;
    logic [CNT_W-1:0]      refresh_q, refresh_d;
    scan_idx_t             scan_q, scan_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  carry;
    logic [3:0]            digit;
    logic [6:0]            seg_dec;

    // Out-of-range tenths (10-15) never match 9 or 0 as a pair, so no carry.
    assign carry         = (prev_tenths_q == 4'd9) && (tenths == 4'd0);
    assign prev_tenths_d = tenths;

    always_comb begin
        time_d     = time_q;
        rollover_d = 1'b0;
        if (carry) begin
            if (time_q.sec_ones == 4'd9) begin
                time_d.sec_ones = 4'd0;
                if (time_q.sec_tens == 3'd5) begin
                    time_d.sec_tens = 3'd0;
                    if (time_q.minutes == 4'd9) begin
                        time_d.minutes = 4'd0;
                        rollover_d     = 1'b1;
                    end else begin
                        time_d.minutes = time_q.minutes + 4'd1;
                    end
                end else begin
                    time_d.sec_tens = time_q.sec_tens + 3'd1;
                end
            end else begin
                time_d.sec_ones = time_q.sec_ones + 4'd1;
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        scan_d    = scan_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            scan_d    = scan_q + scan_idx_t'(1);
        end
    end

    // The tenths digit comes straight from the input so it is never a cycle stale.
    always_comb begin
        digit = tenths;
        case (scan_q)
            2'd0:    digit = tenths;
            2'd1:    digit = time_q.sec_ones;
            2'd2:    digit = {1'b0, time_q.sec_tens};
            default: digit = time_q.minutes;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_comb begin
        an_d  = anode_for(scan_q);
        seg_d = seg_dec;
        dp_d  = (scan_q != scan_idx_t'(DP_DIGIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (!reset) begin
            prev_tenths_q <= 4'd0;
            time_q        <= '0;
            rollover_q    <= 1'b0;
            refresh_q     <= '0;
            scan_q        <= '0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            prev_tenths_q <= prev_tenths_d;
            time_q        <= time_d;
            rollover_q    <= rollover_d;
            refresh_q     <= refresh_d;
            scan_q        <= scan_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign sec_ones = time_q.sec_ones;
    assign sec_tens = time_q.sec_tens;
    assign minutes  = time_q.minutes;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: vector table, directed corner
// sequences and random tenths traffic against an elapsed-seconds model.
module tb_stopwatch_display;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] tenths;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] minutes;
    logic       rollover;

    stopwatch_display #(.REFRESH_CYCLES(R)) dut (
        .clk      (clk),
        .reset    (reset),
        .tenths   (tenths),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .minutes  (minutes),
        .rollover (rollover)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: elapsed whole seconds (mod 600), edges since reset, last tenths seen.
    int         m_total;
    int         m_k;
    logic [3:0] m_prev;
    logic [6:0] seg_tab [10];

    typedef struct {
        logic [3:0] t;
        logic [3:0] exp_ones;
        logic       exp_roll;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        if (v >= 0 && v <= 9) return seg_tab[v];
        return 7'h7F;
    endfunction

    task automatic reset_model();
        m_total = 0;
        m_k     = 0;
        m_prev  = 4'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"},       32'(an),       32'hF);
        check({tag, "_seg"},      32'(seg),      32'h7F);
        check({tag, "_dp"},       32'(dp),       32'h1);
        check({tag, "_sec_ones"}, 32'(sec_ones), 32'h0);
        check({tag, "_sec_tens"}, 32'(sec_tens), 32'h0);
        check({tag, "_minutes"},  32'(minutes),  32'h0);
        check({tag, "_rollover"}, 32'(rollover), 32'h0);
    endtask

    // Called at a negedge: drive t, predict, clock once, compare at the next negedge.
    task automatic cycle(input logic [3:0] t);
        int         scan;
        int         digit;
        logic [3:0] exp_an;
        logic       exp_roll;
        bit         carry;
        tenths = t;
        scan   = (m_k / R) % 4;
        case (scan)
            0:       digit = int'(t);
            1:       digit = m_total % 10;
            2:       digit = (m_total % 60) / 10;
            default: digit = (m_total / 60) % 10;
        endcase
        exp_an       = 4'b1111;
        exp_an[scan] = 1'b0;
        carry    = (m_prev == 4'd9) && (t == 4'd0);
        exp_roll = carry && (m_total == 599);
        if (carry) m_total = (m_total + 1) % 600;
        m_prev = t;
        m_k++;
        @(posedge clk);
        @(negedge clk);
        check("an",       32'(an),       32'(exp_an));
        check("seg",      32'(seg),      32'(seg_of(digit)));
        check("dp",       32'(dp),       32'(scan != 1));
        check("sec_ones", 32'(sec_ones), 32'(m_total % 10));
        check("sec_tens", 32'(sec_tens), 32'((m_total % 60) / 10));
        check("minutes",  32'(minutes),  32'((m_total / 60) % 10));
        check("rollover", 32'(rollover), 32'(exp_roll));
    endtask

    task automatic run_carries_to(input int target);
        while (m_total < target) begin
            cycle(4'd9);
            cycle(4'd0);
        end
    endtask

    initial begin
        logic [3:0] nt;
        int         cnt_dp_any;
        int         cnt_dp_1101;
        int         cnt_min3;
        int         guard;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 10; i++) vecs[i] = '{t: 4'(i), exp_ones: 4'd0, exp_roll: 1'b0};
        vecs[10] = '{t: 4'd0,  exp_ones: 4'd1, exp_roll: 1'b0};
        vecs[11] = '{t: 4'd12, exp_ones: 4'd1, exp_roll: 1'b0};
        vecs[12] = '{t: 4'd0,  exp_ones: 4'd1, exp_roll: 1'b0};

        reset  = 1'b0;
        tenths = 4'd0;
        reset_model();
        repeat (5) begin
            @(negedge clk);
            check_reset_vals("in_reset");
        end
        reset = 1'b1;

        cycle(4'd0);
        check("an_first_edge", 32'(an), 32'b1110);

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].t);
            check("tbl_sec_ones", 32'(sec_ones), 32'(vecs[i].exp_ones));
            check("tbl_rollover", 32'(rollover), 32'(vecs[i].exp_roll));
        end

        // Walk up to 9:59 and take the final wrap.
        run_carries_to(599);
        check("pre_wrap_minutes", 32'(minutes), 32'd9);
        cycle(4'd9);
        cycle(4'd0);
        check("wrap_minutes",  32'(minutes),  32'd0);
        check("wrap_sec_tens", 32'(sec_tens), 32'd0);
        check("wrap_sec_ones", 32'(sec_ones), 32'd0);
        check("wrap_rollover", 32'(rollover), 32'd1);
        cycle(4'd1);
        check("wrap_rollover_drop", 32'(rollover), 32'd0);

        // Fresh start, count to 3:27 and watch one full frame showing 3:27.5.
        reset = 1'b0;
        #1;
        check_reset_vals("reset2");
        @(negedge clk);
        reset = 1'b1;
        reset_model();
        run_carries_to(207);
        cnt_dp_any  = 0;
        cnt_dp_1101 = 0;
        cnt_min3    = 0;
        for (int i = 0; i < 4 * R; i++) begin
            cycle(4'd5);
            if (dp == 1'b0) cnt_dp_any++;
            if (dp == 1'b0 && an == 4'b1101 && seg == 7'h30 - 7'h30 + 7'h78) cnt_dp_1101++;
            if (an == 4'b0111 && seg == 7'h30) cnt_min3++;
        end
        check("frame_dp_low_count",   32'(cnt_dp_any),  32'(R));
        check("frame_dp_on_sec_ones", 32'(cnt_dp_1101), 32'(R));
        check("frame_minutes_digit",  32'(cnt_min3),    32'(R));

        // Random upstream traffic: mostly counting, with occasional arbitrary codes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) nt = 4'($urandom_range(0, 15));
            else                          nt = (m_prev >= 4'd9) ? 4'd0 : m_prev + 4'd1;
            cycle(nt);
        end

        // Asynchronous reset while the sec_tens digit is on.
        guard = 0;
        while (an !== 4'b1011 && guard < 16) begin
            cycle((m_prev >= 4'd9) ? 4'd0 : m_prev + 4'd1);
            guard++;
        end
        check("wait_an_1011", 32'(an), 32'b1011);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b1;
        reset_model();
        cycle(4'd0);
        check("an_after_async_reset", 32'(an), 32'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Downstream stage of the tenths-of-second counter. Consumes its 0–9 tenths digit, detects the 9→0 wrap to carry into seconds (0–59) and minutes (0–9), and time-multiplexes the four digits M.SS.t onto a common-anode 4-digit seven-segment display. Top-level stopwatch display path; outputs drive board pins directly.

## Interface
Parameters:
- REFRESH_CYCLES, 50_000: clk cycles each digit stays enabled (1 kHz/digit at 50 MHz); legal range ≥ 2.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset; one clock; all state clears while low
- tenths  input  4  BCD tenths digit from the upstream counter, synchronous to clk
- an  output  4  digit enables, active-low; an[0] = rightmost (tenths), an[3] = minutes
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- sec_ones  output  4  BCD seconds units
- sec_tens  output  3  seconds tens, 0–5
- minutes  output  4  BCD minutes, 0–9
- rollover  output  1  one-cycle pulse on 9:59.9 → 0:00.0 wrap

## Operation
- prev_tenths register tracks tenths each cycle; carry = (prev_tenths == 9) && (tenths == 0).
- On carry: sec_ones increments; 9→0 carries into sec_tens; sec_tens 5→0 carries into minutes; minutes 9→0 with all lower digits wrapping asserts rollover for exactly that cycle.
- tenths > 9: no carry generated, that digit displays blank (seg = 7'h7F); prev_tenths still updates, so 15→0 produces no carry.
- Refresh counter counts 0..REFRESH_CYCLES-1; on terminal count scan index advances 0→1→2→3→0.
- Digit mux by scan index: 0 tenths, 1 sec_ones, 2 sec_tens (zero-extended), 3 minutes.
- dp low only when scan index = 1 (point between seconds and tenths); high otherwise.
- Exactly one an bit low at any time after reset release; an and seg always reflect the same scan index.
- Reset values: an = 4'hF, seg = 7'h7F, dp = 1, sec_ones = 0, sec_tens = 0, minutes = 0, rollover = 0, prev_tenths = 0, scan index = 0, refresh counter = 0.

## Timing
- Carry: tenths changes 9→0 at edge N; seconds outputs show new value after edge N+1 (one-cycle latency); rollover high during cycle N+1 to N+2.
- an, seg, dp all registered: they reflect scan index and digit values one cycle after those change.
- First cycle after reset deasserts: an = 4'b1110 (tenths digit) from the first clk edge onward.
- Digit period exactly REFRESH_CYCLES clocks; full frame 4×REFRESH_CYCLES.
- Reset asserted mid-count or mid-scan: all outputs go to reset values immediately (asynchronous), independent of clk.
- Carry coinciding with refresh terminal count: both take effect on the same edge; no interaction.

## Structure
- Package stopwatch_pkg: NUM_DIGITS = 4, SEG_BLANK = 7'h7F, DP_DIGIT = 1, BCD → active-low seven-segment code constants for 0–9.
- Sub-module seg7_decoder: combinational 4-bit BCD → 7-bit active-low segments, blank for 10–15; instantiated once after the digit mux, output registered in stopwatch_display.
- Time counters, refresh counter, scan index and output registers live in stopwatch_display.

## Test plan
- Reset low 5 cycles then release -> an = 4'hF, seg = 7'h7F, dp = 1 during reset; an = 4'b1110 after first edge; all counters 0.
- Drive tenths 0..9 then 0 -> sec_ones = 1 one cycle after the 9→0 edge; no change on other transitions.
- Preload to 9:59 by issuing 599 carries, then tenths 9→0 -> minutes/sec_tens/sec_ones = 0/0/0 and rollover high exactly one cycle.
- REFRESH_CYCLES = 4, time 3:27.5 -> an cycles 1110,1101,1011,0111 every 4 clocks with seg codes for 5,7,2,3; dp low only with an = 1101.
- tenths = 12 then 0 -> tenths digit shows blank, no carry, sec_ones unchanged.
- Assert reset mid-scan while an = 4'b1011 -> outputs return to reset values asynchronously before the next edge.
